// File: rtl/modcnt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : modcnt_seq_ctrl
// Brief    : Sequencer for a programmable modulo-M counter. It supports three
//            count styles: clear-to-zero up-count, preload down-count and
//            offset preload up-count. A run is configured and started with a
//            handshake. The counter then runs N full wrap periods, gated by
//            en, and pulses done when the run completes.
// Revision : 1.0 - initial release
// ============================================================================
module modcnt_seq_ctrl #(
    parameter int W     = 4,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     modulus,
    input  logic [CYC_W-1:0] cycles,
    input  logic             en,
    input  logic             abort,
    output logic [W-1:0]     count,
    output logic             wrap,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [0:0]       c_IDLE    = 1'b0;
    localparam logic [0:0]       c_RUN     = 1'b1;
    localparam logic [1:0]       c_MODE_DN = 2'd1;
    localparam logic [1:0]       c_MODE_OF = 2'd2;
    localparam logic [1:0]       c_MODE_IL = 2'd3;
    localparam logic [W-1:0]     c_ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] c_PONE    = {{(CYC_W-1){1'b0}}, 1'b1};

    // First value of every period for a given style and modulus.
    function automatic logic [W-1:0] f_start_val(input logic [1:0] md, input logic [W-1:0] m);
        case (md)
            c_MODE_DN: f_start_val = m - c_ONE;
            c_MODE_OF: f_start_val = '0 - m;      // 2^W - M, wraps naturally
            default:   f_start_val = '0;
        endcase
    endfunction

    // Last value of every period; offset mode ends on all-ones so the
    // increment stops at T and never rolls over to zero.
    function automatic logic [W-1:0] f_term_val(input logic [1:0] md, input logic [W-1:0] m);
        case (md)
            c_MODE_DN: f_term_val = '0;
            c_MODE_OF: f_term_val = '1;
            default:   f_term_val = m - c_ONE;
        endcase
    endfunction

    logic [0:0]       r_state, w_state_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic [W-1:0]     r_mod, w_mod_nxt;
    logic [CYC_W-1:0] r_ncyc, w_ncyc_nxt;
    logic [CYC_W-1:0] r_pcnt, w_pcnt_nxt;
    logic [W-1:0]     r_count, w_count_nxt;
    logic             r_wrap, w_wrap_nxt;
    logic             r_done, w_done_nxt;
    logic             r_cfg_err, w_cfg_err_nxt;

    logic             w_cfg_ok;
    logic [W-1:0]     w_run_start;
    logic [W-1:0]     w_run_term;
    logic [CYC_W-1:0] w_pcnt_inc;

    assign w_cfg_ok    = (modulus > c_ONE) && (mode != c_MODE_IL) && (cycles != '0);
    assign w_run_start = f_start_val(r_mode, r_mod);
    assign w_run_term  = f_term_val(r_mode, r_mod);
    assign w_pcnt_inc  = r_pcnt + c_PONE;

    // Next-state and next-output logic for the IDLE/RUN sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_mod_nxt     = r_mod;
        w_ncyc_nxt    = r_ncyc;
        w_pcnt_nxt    = r_pcnt;
        w_count_nxt   = r_count;
        w_wrap_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_cfg_err_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_mode_nxt  = mode;
                        w_mod_nxt   = modulus;
                        w_ncyc_nxt  = cycles;
                        w_pcnt_nxt  = '0;
                        w_count_nxt = f_start_val(mode, modulus);
                        w_state_nxt = c_RUN;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end
            c_RUN: begin
                if (abort) begin
                    w_count_nxt = '0;
                    w_state_nxt = c_IDLE;
                end else if (en) begin
                    if (r_count == w_run_term) begin
                        w_count_nxt = w_run_start;
                        w_wrap_nxt  = 1'b1;
                        w_pcnt_nxt  = w_pcnt_inc;
                        if (w_pcnt_inc == r_ncyc) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = c_IDLE;
                        end
                    end else if (r_mode == c_MODE_DN) begin
                        w_count_nxt = r_count - c_ONE;
                    end else begin
                        w_count_nxt = r_count + c_ONE;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_mode    <= '0;
            r_mod     <= '0;
            r_ncyc    <= '0;
            r_pcnt    <= '0;
            r_count   <= '0;
            r_wrap    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_mod     <= w_mod_nxt;
            r_ncyc    <= w_ncyc_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_count   <= w_count_nxt;
            r_wrap    <= w_wrap_nxt;
            r_done    <= w_done_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    assign count   = r_count;
    assign wrap    = r_wrap;
    assign busy    = (r_state == c_RUN);
    assign done    = r_done;
    assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_modcnt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_modcnt_seq_ctrl
// Brief    : Self-checking bench for modcnt_seq_ctrl: fixed vector table,
//            directed multi-cycle sequences and random stimulus compared
//            against a period/offset reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modcnt_seq_ctrl;

    localparam int W     = 4;
    localparam int CYC_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic [W-1:0]     modulus;
    logic [CYC_W-1:0] cycles;
    logic             en;
    logic             abort;
    logic [W-1:0]     count;
    logic             wrap;
    logic             busy;
    logic             done;
    logic             cfg_err;

    modcnt_seq_ctrl #(.W(W), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .modulus(modulus),
        .cycles(cycles), .en(en), .abort(abort), .count(count), .wrap(wrap),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a run is a period index p and an offset k into it.
    bit m_run;
    int m_mode, m_M, m_N, m_k, m_p, m_count;
    bit m_wrap, m_done, m_cfg;

    function automatic int pos(input int md, input int m, input int k);
        if (md == 1) return m - 1 - k;
        if (md == 2) return (1 << W) - m + k;
        return k;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_wrap = 0; m_done = 0; m_cfg = 0;
        if (rst) begin
            m_run = 0; m_count = 0; m_k = 0; m_p = 0;
        end else if (!m_run) begin
            if (start) begin
                if (modulus >= 2 && mode != 3 && cycles != 0) begin
                    m_mode = mode; m_M = modulus; m_N = cycles;
                    m_k = 0; m_p = 0; m_run = 1;
                    m_count = pos(m_mode, m_M, 0);
                end else begin
                    m_cfg = 1;
                end
            end
        end else if (abort) begin
            m_run = 0; m_count = 0;
        end else if (en) begin
            if (m_k == m_M - 1) begin
                m_k = 0; m_p++; m_wrap = 1;
                if (m_p == m_N) begin
                    m_done = 1; m_run = 0;
                end
            end else begin
                m_k++;
            end
            m_count = pos(m_mode, m_M, m_k);
        end
    endtask

    task automatic cyc(input bit r, input bit s, input int md, input int m, input int n,
                       input bit e, input bit a);
        rst = r; start = s; mode = md[1:0]; modulus = m[W-1:0];
        cycles = n[CYC_W-1:0]; en = e; abort = a;
        model_step();
        @(posedge clk); #1;
        chk("count", int'(count), m_count);
        chk("busy", int'(busy), int'(m_run));
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("done", int'(done), int'(m_done));
        chk("cfg_err", int'(cfg_err), int'(m_cfg));
    endtask

    typedef struct {
        bit s; int md; int m; int n; bit e; bit a;
        int ecount; bit ewrap; bit ebusy; bit edone; bit ecfg;
    } vec_t;

    vec_t tbl[16];

    initial begin
        rst = 1; start = 0; mode = 0; modulus = 0; cycles = 0; en = 0; abort = 0;

        //        s  md m  n  e  a  cnt wr bs dn cfg
        tbl[0]  = '{1, 0, 1, 2, 0, 0, 0,  0, 0, 0, 1};
        tbl[1]  = '{1, 0, 0, 2, 0, 0, 0,  0, 0, 0, 1};
        tbl[2]  = '{0, 0, 0, 2, 0, 0, 0,  0, 0, 0, 0};
        tbl[3]  = '{1, 3, 5, 2, 0, 0, 0,  0, 0, 0, 1};
        tbl[4]  = '{1, 0, 5, 0, 0, 0, 0,  0, 0, 0, 1};
        tbl[5]  = '{1, 1, 3, 1, 1, 0, 2,  0, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 1, 0, 1,  0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, 2,  1, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 0, 2,  0, 0, 0, 0};
        tbl[10] = '{1, 2, 3, 1, 0, 0, 13, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 13, 0, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 0, 14, 0, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 1, 0, 15, 0, 1, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0};

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Fixed vector table
        for (int i = 0; i < 16; i++) begin
            rst = 0; start = tbl[i].s; mode = tbl[i].md[1:0]; modulus = tbl[i].m[W-1:0];
            cycles = tbl[i].n[CYC_W-1:0]; en = tbl[i].e; abort = tbl[i].a;
            @(posedge clk); #1;
            chk("tbl_count", int'(count), tbl[i].ecount);
            chk("tbl_wrap", int'(wrap), int'(tbl[i].ewrap));
            chk("tbl_busy", int'(busy), int'(tbl[i].ebusy));
            chk("tbl_done", int'(done), int'(tbl[i].edone));
            chk("tbl_cfg_err", int'(cfg_err), int'(tbl[i].ecfg));
        end
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Mode 0, M=11, N=2
        cyc(0, 1, 0, 11, 2, 1, 0);
        for (int i = 0; i < 24; i++) cyc(0, 0, 0, 11, 2, 1, 0);
        // Mode 1, M=11, N=1
        cyc(0, 1, 1, 11, 1, 1, 0);
        for (int i = 0; i < 13; i++) cyc(0, 0, 1, 11, 1, 1, 0);
        // Mode 2, M=11, N=1: runs 5..15 with no rollover
        cyc(0, 1, 2, 11, 1, 1, 0);
        for (int i = 0; i < 13; i++) cyc(0, 0, 2, 11, 1, 1, 0);
        // Enable gaps in mode 0, M=3, N=1
        cyc(0, 1, 0, 3, 1, 1, 0);
        cyc(0, 0, 0, 3, 1, 1, 0);
        cyc(0, 0, 0, 3, 1, 0, 0);
        cyc(0, 0, 0, 3, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 3, 1, 1, 0);
        // Illegal starts
        cyc(0, 1, 0, 1, 2, 1, 0);
        cyc(0, 1, 0, 0, 2, 1, 0);
        cyc(0, 1, 3, 5, 2, 1, 0);
        cyc(0, 1, 0, 5, 0, 1, 0);
        cyc(0, 0, 0, 5, 0, 1, 0);
        // Abort at count=3 in period 2, then same with reset
        cyc(0, 1, 0, 5, 3, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 5, 3, 1, 0);
        cyc(0, 0, 0, 5, 3, 1, 1);
        cyc(0, 0, 0, 5, 3, 1, 0);
        cyc(0, 1, 0, 5, 3, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 5, 3, 1, 0);
        cyc(1, 0, 0, 5, 3, 1, 0);
        cyc(0, 0, 0, 5, 3, 1, 0);
        // Start held high with modulus changing mid-run
        cyc(0, 1, 0, 4, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 7, 1, 1, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 9, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Random stimulus
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
                ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modcnt_seq_ctrl.md
Name: modcnt_seq_ctrl

Overview:
Sequencer for a programmable modulo-M counter. It supports three count styles: feedback-clear up-count, preload down-count, and offset preload up-count. Each run is configured once and started with a handshake. The counter then runs a programmed number of full wrap periods, gated by a count enable, and signals completion. This block is the shared front end for the team's modulo counter datapaths, replacing the hard-coded fixed-modulus counter variants.

Parameters:
W, 4, counter width in bits; legal modulus range is 2..2^W-1
CYC_W, 8, width of the wrap-period count

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  run request; sampled only in IDLE
mode  input  2  0 = up/clear, 1 = down/preload, 2 = up/offset, 3 = illegal
modulus  input  W  modulus M
cycles  input  CYC_W  number of wrap periods to run (N)
en  input  1  count enable during RUN
abort  input  1  stop the run immediately
count  output  W  counter value
wrap  output  1  one-cycle pulse per completed period
busy  output  1  high while in RUN
done  output  1  one-cycle pulse at normal completion
cfg_err  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Only one clock, clk. Reset rst is synchronous, active-high: on a clk edge with rst=1, the state goes to IDLE and count=0, wrap=0, busy=0, done=0, cfg_err=0, internal period counter=0.
- rst has priority over abort, abort over start/en.
- Per-mode start value S and terminal value T, computed from the latched M:
  - mode 0: S=0, T=M-1
  - mode 1: S=M-1, T=0
  - mode 2: S=2^W-M, T=2^W-1, computed modulo 2^W
- FSM states: IDLE, RUN.
- IDLE, start=1 with a legal configuration (M>=2, mode!=3, N!=0):
  - latch mode, M and N at that edge; later changes to these inputs are ignored until the next IDLE.
  - count<=S, period counter<=0, busy<=1, go to RUN.
- IDLE, start=1 with an illegal configuration:
  - cfg_err pulses in the following cycle.
  - stay in IDLE; count and busy are unchanged.
- IDLE, start=0: count holds its value.
- RUN, en=0: count and period counter hold; wrap=0.
- RUN, en=1, count!=T: count steps toward T (+1 in modes 0 and 2, -1 in mode 1).
- RUN, en=1, count==T:
  - count<=S and wrap<=1 (wrap is high for one cycle, aligned with count showing S); period counter increments.
  - if this was period N: at the same edge done<=1, busy<=0, go to IDLE; count stays S.
- wrap and done are registered pulses, each high for exactly one cycle.
- start while in RUN is ignored: no restart, no cfg_err.
- abort in RUN: next edge goes to IDLE, count<=0, busy<=0, no done, no wrap. abort in IDLE has no effect.
- rst mid-run: the run is discarded, all outputs take reset values, no done.
- A run lasts N*M enabled edges, plus any en=0 cycles.
- No arithmetic ever leaves the range [S..T]. Mode 2 with T=all-ones must not overflow past T.
- count never shows a value outside the period range while busy=1.

Test Plan:
- W=4, mode0, M=11, N=2, en=1: count 0,1..10,0,1..10,0; wrap high on both returns to 0; done pulses with busy dropping after the 22nd RUN edge; count holds 0 afterwards.
- mode1, M=11, N=1: count 10,9..0,10; one wrap, and done in the same cycle; busy is high for exactly 11 cycles. Then mode2, M=11: count 5,6..15,5; no overflow to 0.
- en toggled 1,0,0,1 mid-period in mode0, M=3, N=1: count holds during en=0 cycles; done is delayed by exactly 2 cycles.
- start with M=1, then M=0, then mode=3, then N=0: cfg_err pulses each time; busy stays 0; count unchanged.
- mode0, M=5, N=3, abort at count=3 in period 2: count 0, busy 0, no done. Repeat with rst instead of abort: all outputs 0 the next cycle.
- start held high through a whole run, with modulus changed mid-run: the original M is used throughout; a new run starts only on the first IDLE cycle after done.
